// File: rtl/lfsr_gen_p.sv
// Parametrised Fibonacci/Galois LFSR with period-end tick, zero-state lockup guard
// and optional per-period ones/zeros statistics (enable with `define LFSR_STATS_EN).
module lfsr_gen_p #(
  parameter int unsigned      WIDTH = 13,
  parameter logic [WIDTH-1:0] TAPS  = 13'h101B,
  parameter logic [WIDTH-1:0] SEED  = 13'h19C3,
  parameter int unsigned      MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             bit_out,
  output logic             max_tick,
  output logic             lockup,
  output logic [WIDTH-1:0] final_ones,
  output logic [WIDTH-1:0] final_zeros
);

  // Step count of the last step in a period (PERIOD - 1 = 2^WIDTH - 2).
  localparam logic [WIDTH-1:0] PERIOD_M1 = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             max_tick_q, max_tick_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] next_c;
  logic             zero_c, adv_c, wrap_c;

  if (MODE == 0) begin : g_fib
    assign bit_out = ^(lfsr_q & TAPS);
    assign next_c  = {lfsr_q[WIDTH-2:0], bit_out};
  end else begin : g_gal
    assign bit_out = lfsr_q[WIDTH-1];
    assign next_c  = {lfsr_q[WIDTH-2:0], 1'b0} ^ (bit_out ? TAPS : '0);
  end

  assign zero_c = (lfsr_q == '0);
  assign adv_c  = en & ~load & ~zero_c;
  assign wrap_c = adv_c & (cnt_q == PERIOD_M1);

  // Register/step-counter next state: load > lockup recovery > step > hold.
  always_comb begin
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    max_tick_d = wrap_c;
    lockup_d   = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (load_val == '0) begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        lfsr_d = load_val;
      end
    end else if (en) begin
      if (zero_c) begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
        cnt_d    = '0;
      end else begin
        lfsr_d = next_c;
        cnt_d  = wrap_c ? '0 : cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      max_tick_q <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      max_tick_q <= max_tick_d;
      lockup_q   <= lockup_d;
    end
  end

  assign lfsr_out = lfsr_q;
  assign max_tick = max_tick_q;
  assign lockup   = lockup_q;

`ifdef LFSR_STATS_EN
  logic [WIDTH-1:0] run_ones_q, run_ones_d;
  logic [WIDTH-1:0] run_zeros_q, run_zeros_d;
  logic [WIDTH-1:0] final_ones_q, final_ones_d;
  logic [WIDTH-1:0] final_zeros_q, final_zeros_d;
  logic [WIDTH-1:0] sum_ones_c, sum_zeros_c;
  logic             clr_c;

  assign clr_c       = load | (en & zero_c);
  assign sum_ones_c  = run_ones_q + WIDTH'(bit_out);
  assign sum_zeros_c = run_zeros_q + WIDTH'(~bit_out);

  // Running counts include the bit consumed by the current step; finals latch at wrap.
  always_comb begin
    run_ones_d    = run_ones_q;
    run_zeros_d   = run_zeros_q;
    final_ones_d  = final_ones_q;
    final_zeros_d = final_zeros_q;
    if (clr_c) begin
      run_ones_d  = '0;
      run_zeros_d = '0;
    end else if (wrap_c) begin
      final_ones_d  = sum_ones_c;
      final_zeros_d = sum_zeros_c;
      run_ones_d    = '0;
      run_zeros_d   = '0;
    end else if (adv_c) begin
      run_ones_d  = sum_ones_c;
      run_zeros_d = sum_zeros_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_ones_q    <= '0;
      run_zeros_q   <= '0;
      final_ones_q  <= '0;
      final_zeros_q <= '0;
    end else begin
      run_ones_q    <= run_ones_d;
      run_zeros_q   <= run_zeros_d;
      final_ones_q  <= final_ones_d;
      final_zeros_q <= final_zeros_d;
    end
  end

  assign final_ones  = final_ones_q;
  assign final_zeros = final_zeros_q;
`else
  assign final_ones  = '0;
  assign final_zeros = '0;
`endif

endmodule

// File: doc/lfsr_gen_p.md
Name: lfsr_gen_p

Overview:
- Parametrised pseudo-random bit/word generator with selectable feedback architecture (Fibonacci or Galois), run enable and runtime seed load.
- Per-period statistics: running ones/zeros count of the output bit stream, latched at each period end and flagged with a single-cycle max_tick.
- Zero-state lockup protection.
- Sits in the test-pattern/noise sources alongside the 13-bit XOR generator and supersedes it for new instances.

Parameters:
- WIDTH, 13, register width; legal range 3..32.
- TAPS, 13'h101B, feedback mask, WIDTH bits; bit i set means register bit i is a tap. Must describe a maximal-length polynomial for the statistics to be meaningful.
- SEED, 13'h19C3, non-zero value loaded at reset and on lockup recovery.
- MODE, 0, feedback architecture: 0 = Fibonacci, 1 = Galois.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance one step this cycle.
- load  in  1  load load_val this cycle.
- load_val  in  WIDTH  value to load.
- lfsr_out  out  WIDTH  current register contents.
- bit_out  out  1  bit produced by the next step, combinational from the register.
- max_tick  out  1  one-cycle pulse at period end.
- lockup  out  1  one-cycle pulse when a zero state is replaced by SEED.
- final_ones  out  WIDTH  ones count of the last completed period.
- final_zeros  out  WIDTH  zeros count of the last completed period.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Reset values: lfsr_out = SEED; max_tick = 0; lockup = 0; final_ones = 0; final_zeros = 0; step counter = 0; running counters = 0.
- Priority each cycle: reset > load > en > hold.
- Fibonacci step (MODE 0):
  - fb = XOR-reduce(reg & TAPS).
  - next = {reg[WIDTH-2:0], fb}.
  - bit_out = fb.
- Galois step (MODE 1):
  - msb = reg[WIDTH-1].
  - next = {reg[WIDTH-2:0], 0} XOR (msb ? TAPS : 0).
  - bit_out = msb.
- Step counter:
  - WIDTH bits wide; counts enabled steps since the last reset/load.
  - PERIOD = 2^WIDTH - 1.
- Each enabled step:
  - Register updates to next.
  - The bit_out value consumed by that step increments run_ones or run_zeros.
  - Step counter increments.
- Period end: on the enabled step where the step counter equals PERIOD-1:
  - Next cycle max_tick = 1.
  - final_ones/final_zeros latch the running counts including this step's bit.
  - Running counters and step counter clear to 0.
  - max_tick stays 1 for exactly one cycle, then returns to 0.
- en = 0: register, counters and finals hold; max_tick and lockup deassert.
- Load:
  - Register takes load_val; step counter and running counters clear; finals retain their values; no max_tick.
  - If load_val == 0, register takes SEED instead and lockup pulses the next cycle.
  - load with en = 1 performs the load only.
- Lockup guard: if the register is ever all-zero while en = 1, that step loads SEED instead of next, pulses lockup, and clears the step and running counters.
- Counter width rule: ones per period are at most 2^(WIDTH-1), so both counts fit in WIDTH bits with no saturation required.
- Reset asserted mid-period: all state returns to reset values on that edge; a partially accumulated period is discarded.

Optional Feature:
- Macro: LFSR_STATS_EN.
- Defined: running counters and final_ones/final_zeros are implemented as above.
- Undefined: running counters are not built; final_ones and final_zeros are tied to 0. max_tick, the step counter and lockup behave identically.

Test Plan:
- Reset (WIDTH=4, TAPS=4'b1001, SEED=4'b0001, MODE 0): assert reset 2 cycles → lfsr_out = 0001, max_tick = 0, final_ones = 0, final_zeros = 0.
- Same configuration, en = 1 continuously:
  - First outputs are 0011, 0111, 1111, 1110.
  - After 15 steps, lfsr_out = 0001; max_tick pulses exactly one cycle; final_ones = 8, final_zeros = 7.
  - A second period repeats the identical pulse 15 cycles later.
- en toggled 1/0 every cycle over 30 cycles → identical sequence at half rate; max_tick after the 15th enabled step; finals 8/7.
- load with load_val = 0110 mid-period → lfsr_out = 0110; previous finals retained; next max_tick arrives exactly 15 enabled steps later.
- load with load_val = 0 → lfsr_out = SEED (0001) and lockup pulses 1 cycle.
- MODE 1, WIDTH=4, TAPS=4'b0011, SEED=0001 → 15-step period; max_tick; finals 8/7. Without LFSR_STATS_EN, finals remain 0 while max_tick timing is unchanged.
